// File: rtl/triloc_seq_ctrl_pkg.sv
// Shared types and core_p slice offsets for the TriLoc sequencer.
package triloc_pkg;

  localparam int unsigned LAT_W = 4;

  typedef enum logic [2:0] {
    GET_A,
    GET_B,
    GET_C,
    WAIT,
    DIV,
    OUT
  } state_t;

  // rec: 0=A, 1=B, 2=C. Coordinates sit above the three packed ranges.
  function automatic int unsigned xy_lsb(int unsigned n, int unsigned rec, int unsigned is_y);
    return (8 - 2 * rec - is_y) * n + 3;
  endfunction

  function automatic int unsigned r_lsb(int unsigned n, int unsigned rec);
    return (2 - rec) * (n + 1);
  endfunction

endpackage

// File: rtl/triloc_seq_ctrl_if.sv
// Anchor-record input stream and result output stream of the TriLoc sequencer.
interface triloc_seq_ctrl_if #(
  parameter int unsigned N = 8
);
  logic                s_valid;
  logic                s_ready;
  logic [N-1:0]        s_x;
  logic [N-1:0]        s_y;
  logic [N:0]          s_r;
  logic                m_valid;
  logic                m_ready;
  logic signed [N+3:0] m_x;
  logic signed [N+3:0] m_y;

  modport master (
    output s_valid, s_x, s_y, s_r, m_ready,
    input  s_ready, m_valid, m_x, m_y
  );

  modport slave (
    input  s_valid, s_x, s_y, s_r, m_ready,
    output s_ready, m_valid, m_x, m_y
  );
endinterface

// File: rtl/triloc_seq_ctrl_div3.sv
// Two-lane sign-magnitude restoring divider by 3; one quotient bit per cycle.
module tri_div3_seq #(
  parameter int unsigned W = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic signed [W-1:0] din_x,
  input  logic signed [W-1:0] din_y,
  output logic                done,
  output logic signed [W-1:0] qx,
  output logic signed [W-1:0] qy
);
  localparam int unsigned CW = $clog2(W);

  logic [W-1:0]  mag   [2];
  logic [W-1:0]  mag_n [2];
  logic [1:0]    rem   [2];
  logic [1:0]    rem_n [2];
  logic          neg   [2];
  logic [W-1:0]  din   [2];
  logic [CW-1:0] cnt;
  logic          run;

  always_comb begin
    din[0] = din_x;
    din[1] = din_y;
  end

  // Dividend shifts out MSB-first while quotient bits shift in behind it.
  always_comb begin
    logic [2:0] t;
    logic       ge;
    t  = '0;
    ge = 1'b0;
    for (int unsigned i = 0; i < 2; i++) begin
      t        = {rem[i], mag[i][W-1]};
      ge       = (t >= 3'd3);
      rem_n[i] = ge ? 2'(t - 3'd3) : t[1:0];
      mag_n[i] = {mag[i][W-2:0], ge};
    end
  end

  assign done = run && (cnt == CW'(W - 1));
  assign qx   = neg[0] ? $signed(-mag_n[0]) : $signed(mag_n[0]);
  assign qy   = neg[1] ? $signed(-mag_n[1]) : $signed(mag_n[1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 1'b0;
      cnt <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        mag[i] <= '0;
        rem[i] <= '0;
        neg[i] <= 1'b0;
      end
    end else if (start) begin
      run <= 1'b1;
      cnt <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        // W-bit unsigned magnitude keeps -2^(W-1) representable.
        mag[i] <= din[i][W-1] ? -din[i] : din[i];
        rem[i] <= '0;
        neg[i] <= din[i][W-1];
      end
    end else if (run) begin
      cnt <= cnt + 1'b1;
      if (done) run <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        mag[i] <= mag_n[i];
        rem[i] <= rem_n[i];
      end
    end
  end
endmodule

// File: rtl/triloc_seq_ctrl.sv
// TriLoc sequencer: gathers three anchor records, waits on the core, divides by 3.
module triloc_seq_ctrl
  import triloc_pkg::*;
#(
  parameter int unsigned N        = 8,
  parameter int unsigned CORE_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  triloc_seq_ctrl_if.slave     bus,
  output logic [9*N+2:0]       core_p,
  input  logic [2*N+7:0]       core_o,
  output logic                 busy
);
  localparam int unsigned XA = xy_lsb(N, 0, 0);
  localparam int unsigned YA = xy_lsb(N, 0, 1);
  localparam int unsigned XB = xy_lsb(N, 1, 0);
  localparam int unsigned YB = xy_lsb(N, 1, 1);
  localparam int unsigned XC = xy_lsb(N, 2, 0);
  localparam int unsigned YC = xy_lsb(N, 2, 1);
  localparam int unsigned RA = r_lsb(N, 0);
  localparam int unsigned RB = r_lsb(N, 1);
  localparam int unsigned RC = r_lsb(N, 2);

  state_t              state;
  logic [LAT_W-1:0]    wcnt;
  logic                accept;
  logic                div_start;
  logic                div_done;
  logic signed [N+3:0] qx;
  logic signed [N+3:0] qy;

  assign accept    = bus.s_valid && bus.s_ready;
  assign div_start = (state == WAIT) && (wcnt == '0);

  // core_o is sampled by the divider on the same edge that leaves WAIT.
  tri_div3_seq #(.W(N + 4)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (div_start),
    .din_x (core_o[2*N+7:N+4]),
    .din_y (core_o[N+3:0]),
    .done  (div_done),
    .qx    (qx),
    .qy    (qy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= GET_A;
      bus.s_ready <= 1'b1;
      bus.m_valid <= 1'b0;
      bus.m_x     <= '0;
      bus.m_y     <= '0;
      core_p      <= '0;
      busy        <= 1'b0;
      wcnt        <= '0;
    end else begin
      case (state)
        GET_A: if (accept) begin
          core_p[XA +: N]   <= bus.s_x;
          core_p[YA +: N]   <= bus.s_y;
          core_p[RA +: N+1] <= bus.s_r;
          busy              <= 1'b1;
          state             <= GET_B;
        end
        GET_B: if (accept) begin
          core_p[XB +: N]   <= bus.s_x;
          core_p[YB +: N]   <= bus.s_y;
          core_p[RB +: N+1] <= bus.s_r;
          state             <= GET_C;
        end
        GET_C: if (accept) begin
          core_p[XC +: N]   <= bus.s_x;
          core_p[YC +: N]   <= bus.s_y;
          core_p[RC +: N+1] <= bus.s_r;
          bus.s_ready       <= 1'b0;
          wcnt              <= LAT_W'(CORE_LAT);
          state             <= WAIT;
        end
        WAIT: begin
          if (wcnt == '0) state <= DIV;
          else            wcnt  <= wcnt - 1'b1;
        end
        DIV: if (div_done) begin
          bus.m_x     <= qx;
          bus.m_y     <= qy;
          bus.m_valid <= 1'b1;
          state       <= OUT;
        end
        OUT: if (bus.m_ready) begin
          bus.m_valid <= 1'b0;
          bus.s_ready <= 1'b1;
          busy        <= 1'b0;
          state       <= GET_A;
        end
        default: state <= GET_A;
      endcase
    end
  end
endmodule

// File: tb/tb_triloc_seq_ctrl.sv
// Randomized scoreboard bench for triloc_seq_ctrl with a one-stage stub core.
module tb_triloc_seq_ctrl;
  localparam int unsigned N        = 8;
  localparam int unsigned CORE_LAT = 1;
  localparam int          LAT      = CORE_LAT + N + 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [9*N+2:0] core_p;
  logic [2*N+7:0] core_o;
  logic [2*N+7:0] core_q = '0;
  logic           busy;

  triloc_seq_ctrl_if #(.N(N)) bus ();

  triloc_seq_ctrl #(.N(N), .CORE_LAT(CORE_LAT)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus.slave),
    .core_p (core_p),
    .core_o (core_o),
    .busy   (busy)
  );

  // Stub core: xM = {rA[3:0], xA}, yM = {rB[3:0], yA}, one register stage.
  always @(posedge clk)
    core_q <= {core_p[2*N+2 +: 4], core_p[8*N+3 +: N], core_p[N+1 +: 4], core_p[7*N+3 +: N]};
  assign core_o = core_q;

  typedef struct {
    int x;
    int y;
    int cacc;
    bit bp;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic signed [127:0] act, logic signed [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endfunction

  // Monitor: pops an expectation when a new result appears, then checks hold/handshake.
  bit   active  = 0;
  bit   prev_hs = 0;
  int   hold    = 0;
  exp_t cur     = '{0, 0, 0, 0};

  always @(negedge clk) begin
    if (!rst_n) begin
      active      = 0;
      prev_hs     = 0;
      bus.m_ready = 1'b0;
    end else begin
      if (prev_hs) begin
        check("hs_m_valid_drop", bus.m_valid, 0);
        check("hs_s_ready_back", bus.s_ready, 1);
        check("hs_busy_clear", busy, 0);
      end
      prev_hs = 0;
      if (bus.m_valid) begin
        if (!active) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got m_x=%0d m_y=%0d with nothing pending", bus.m_x, bus.m_y);
          end else begin
            cur = q.pop_front();
            check("m_x", bus.m_x, cur.x);
            check("m_y", bus.m_y, cur.y);
            check("latency", cyc - cur.cacc, LAT);
            active = 1;
            hold   = 0;
          end
        end else begin
          check("m_x_stable", bus.m_x, cur.x);
          check("m_y_stable", bus.m_y, cur.y);
        end
        check("s_ready_low_out", bus.s_ready, 0);
        check("busy_out", busy, 1);
        if (cur.bp && hold < 20) begin
          bus.m_ready = 1'b0;
          hold++;
        end else begin
          bus.m_ready = cur.bp || ($urandom_range(2, 0) != 0);
        end
        prev_hs = bus.m_ready;
      end else begin
        active      = 0;
        bus.m_ready = 1'($urandom_range(1, 0));
      end
    end
  end

  task automatic send(input logic [N-1:0] x, input logic [N-1:0] y, input logic [N:0] r);
    int unsigned t = 0;
    @(negedge clk);
    while (!bus.s_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!bus.s_ready) begin
      total++;
      bad++;
      $display("FAIL s_ready_timeout: got s_ready=0 want 1 within 500 cycles");
    end
    bus.s_valid = 1'b1;
    bus.s_x     = x;
    bus.s_y     = y;
    bus.s_r     = r;
    @(posedge clk);
    #1 bus.s_valid = 1'b0;
  endtask

  task automatic job(input logic [N-1:0] xa, input logic [N-1:0] ya, input logic [N:0] ra,
                     input logic [N-1:0] xb, input logic [N-1:0] yb, input logic [N:0] rb,
                     input logic [N-1:0] xc, input logic [N-1:0] yc, input logic [N:0] rc,
                     input int gap_max, input bit bp, input bit junk);
    exp_t                e;
    logic signed [N+3:0] xm;
    logic signed [N+3:0] ym;
    logic [9*N+2:0]      packed_exp;
    repeat ($urandom_range(gap_max, 0)) @(negedge clk);
    send(xa, ya, ra);
    repeat ($urandom_range(gap_max, 0)) @(negedge clk);
    send(xb, yb, rb);
    repeat ($urandom_range(gap_max, 0)) @(negedge clk);
    send(xc, yc, rc);
    packed_exp = {xa, ya, xb, yb, xc, yc, ra, rb, rc};
    check("core_p_pack", core_p, packed_exp);
    check("s_ready_after_c", bus.s_ready, 0);
    xm     = {ra[3:0], xa};
    ym     = {rb[3:0], ya};
    e.x    = int'(xm) / 3;
    e.y    = int'(ym) / 3;
    e.cacc = cyc;
    e.bp   = bp;
    q.push_back(e);
    if (junk) begin
      repeat (8) begin
        @(negedge clk);
        bus.s_valid = !bus.s_ready && ($urandom_range(1, 0) != 0);
        bus.s_x     = N'($urandom);
        bus.s_y     = N'($urandom);
        bus.s_r     = (N+1)'($urandom);
      end
      @(negedge clk);
      bus.s_valid = 1'b0;
    end
  endtask

  task automatic job_xy(input int xm_i, input int ym_i, input int gap_max, input bit bp, input bit junk);
    logic [N+3:0] xm;
    logic [N+3:0] ym;
    logic [N:0]   ra;
    logic [N:0]   rb;
    xm      = (N+4)'(xm_i);
    ym      = (N+4)'(ym_i);
    ra      = (N+1)'($urandom);
    rb      = (N+1)'($urandom);
    ra[3:0] = xm[N+3:N];
    rb[3:0] = ym[N+3:N];
    job(xm[N-1:0], ym[N-1:0], ra, N'($urandom), N'($urandom), rb,
        N'($urandom), N'($urandom), (N+1)'($urandom), gap_max, bp, junk);
  endtask

  function automatic int rand_m();
    return int'($urandom_range(4095, 0)) - 2048;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t;
    bus.s_valid = 1'b0;
    bus.s_x     = '0;
    bus.s_y     = '0;
    bus.s_r     = '0;
    rst_n       = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_s_ready", bus.s_ready, 1);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_x", bus.m_x, 0);
    check("rst_m_y", bus.m_y, 0);
    check("rst_core_p", core_p, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;

    // Packing with the documented anchor set.
    job(N'(-16), N'(-111), (N+1)'(236), N'(109), N'(-99), (N+1)'(183),
        N'(-32), N'(108), (N+1)'(215), 0, 0, 0);

    // Directed divide values, including the most-negative input.
    job_xy(-300, 7, 0, 0, 0);
    job_xy(-7, -2048, 0, 0, 0);
    job_xy(2047, 0, 0, 0, 0);
    job_xy(-2048, -1, 0, 0, 0);

    // Backpressure with ignored s_valid pulses while busy.
    job_xy(rand_m(), rand_m(), 0, 1, 1);

    // Reset mid-DIV aborts the job asynchronously.
    job_xy(rand_m(), rand_m(), 0, 0, 0);
    repeat (CORE_LAT + 4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_m_valid", bus.m_valid, 0);
    check("abort_s_ready", bus.s_ready, 1);
    check("abort_core_p", core_p, 0);
    check("abort_busy", busy, 0);
    void'(q.pop_back());
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    job_xy(-300, 7, 0, 0, 0);

    // Random jobs with gaps, junk pulses and occasional backpressure.
    for (int i = 0; i < 40; i++)
      job_xy(rand_m(), rand_m(), 3, ($urandom_range(7, 0) == 0), ($urandom_range(3, 0) == 0));

    t = 0;
    while ((q.size() != 0 || bus.m_valid) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("queue_drained", q.size(), 0);
    check("final_m_valid", bus.m_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
